// File: rtl/hamming16_arbiter.sv
// hamming16_arbiter: round-robin arbiter sharing one 16-bit popcount datapath
// between N_REQ valid/ready requesters; one result register tagged with the
// requester index. Define HAMMING16_ARBITER_ACCUM_EN to add per-requester
// 21-bit running totals (acc_clr / out_total ports).
module hamming16_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef HAMMING16_ARBITER_ACCUM_EN
  input  logic [N_REQ-1:0]     acc_clr,
  output logic [20:0]          out_total,
`endif
  output logic [4:0]           out_count,
  output logic [ID_W-1:0]      out_id,
  output logic [15:0]          out_data
);

  localparam logic [ID_W:0]   NReqW   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LastIdx = ID_W'(N_REQ - 1);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;

  logic [ID_W-1:0] win_idx;
  logic            win_found;
  logic [ID_W:0]   cand;
  logic            can_accept;
  logic            transfer;
  logic [15:0]     win_data;
  logic [4:0]      win_count;
  logic [ID_W-1:0] next_ptr;

  // Scan from rr_ptr upward, wrapping at N_REQ so unused indices never win.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= NReqW) cand = cand - NReqW;
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Drain and refill in the same cycle is allowed; nothing is granted in reset.
  assign can_accept = (state_q == StEmpty) || out_ready;
  assign transfer   = rst_n && can_accept && win_found;

  // One-hot grant; depends only on req_valid, out_ready and state.
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win_idx] = 1'b1;
  end

  assign win_data = req_data[{win_idx, 4'd0} +: 16];

  // Shared popcount datapath.
  always_comb begin
    win_count = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      win_count = win_count + {4'd0, win_data[i]};
    end
  end

  assign next_ptr  = (win_idx == LastIdx) ? '0 : win_idx + ID_W'(1);
  assign out_valid = (state_q == StFull);

`ifdef HAMMING16_ARBITER_ACCUM_EN
  logic [20:0] total_q [N_REQ];
  logic [20:0] total_new;

  // A clear coinciding with a transfer restarts the total from this word.
  assign total_new = (acc_clr[win_idx] ? 21'd0 : total_q[win_idx]) + {16'd0, win_count};

  // Per-requester running totals, wrapping modulo 2^21.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) total_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (transfer && (win_idx == ID_W'(i))) begin
          total_q[i] <= total_new;
        end else if (acc_clr[i]) begin
          total_q[i] <= '0;
        end
      end
    end
  end
`endif

  // Output register FSM: load on transfer, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      rr_ptr_q  <= '0;
      out_count <= '0;
      out_id    <= '0;
      out_data  <= '0;
`ifdef HAMMING16_ARBITER_ACCUM_EN
      out_total <= '0;
`endif
    end else begin
      if (transfer) begin
        state_q   <= StFull;
        out_count <= win_count;
        out_id    <= win_idx;
        out_data  <= win_data;
        rr_ptr_q  <= next_ptr;
`ifdef HAMMING16_ARBITER_ACCUM_EN
        out_total <= total_new;
`endif
      end else if ((state_q == StFull) && out_ready) begin
        state_q <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_hamming16_arbiter.sv
// Bench for hamming16_arbiter: directed vector table, hand sequences for the
// N_REQ=3 wrap and async reset, then randomized traffic against a model.
module tb_hamming16_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  valid4, ready4;
  logic [63:0] data4;
  logic        ordy4, ov4;
  logic [4:0]  cnt4;
  logic [1:0]  id4;
  logic [15:0] dat4;

  logic [2:0]  valid3, ready3;
  logic [47:0] data3;
  logic        ordy3, ov3;
  logic [4:0]  cnt3;
  logic [1:0]  id3;
  logic [15:0] dat3;

`ifdef HAMMING16_ARBITER_ACCUM_EN
  logic [3:0]  clr4;
  logic [20:0] tot4;
  logic [2:0]  clr3;
  logic [20:0] tot3;
`endif

  hamming16_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (valid4),
    .req_data  (data4),
    .req_ready (ready4),
    .out_valid (ov4),
    .out_ready (ordy4),
`ifdef HAMMING16_ARBITER_ACCUM_EN
    .acc_clr   (clr4),
    .out_total (tot4),
`endif
    .out_count (cnt4),
    .out_id    (id4),
    .out_data  (dat4)
  );

  hamming16_arbiter #(.N_REQ(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (valid3),
    .req_data  (data3),
    .req_ready (ready3),
    .out_valid (ov3),
    .out_ready (ordy3),
`ifdef HAMMING16_ARBITER_ACCUM_EN
    .acc_clr   (clr3),
    .out_total (tot3),
`endif
    .out_count (cnt3),
    .out_id    (id3),
    .out_data  (dat3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the N_REQ=4 instance.
  bit          m_full;
  int          m_id, m_count, m_ptr;
  logic [15:0] m_data;
  logic [20:0] m_total [4];
  logic [20:0] m_out_total;

  task automatic model_reset();
    m_full = 0; m_id = 0; m_count = 0; m_ptr = 0; m_data = '0; m_out_total = '0;
    for (int i = 0; i < 4; i++) m_total[i] = '0;
  endtask

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input logic o);
    logic [3:0] g;
    g = '0;
    if (!m_full || o) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (g == 4'd0 && v[j]) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic [63:0] d, input logic o,
                            input logic [3:0] clr);
    logic [3:0] g;
    int w;
    g = exp_grant(v, o);
    w = -1;
    for (int i = 0; i < 4; i++) if (g[i]) w = i;
    for (int i = 0; i < 4; i++) if (clr[i] && i != w) m_total[i] = '0;
    if (w >= 0) begin
      m_full  = 1;
      m_id    = w;
      m_data  = d[16*w +: 16];
      m_count = $countones(m_data);
      m_ptr   = (w + 1) % 4;
      m_total[w]  = (clr[w] ? 21'd0 : m_total[w]) + 21'(m_count);
      m_out_total = m_total[w];
    end else if (m_full && o) begin
      m_full = 0;
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [1:0]  exp_id;
    logic [4:0]  exp_cnt;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [14];
  localparam logic [63:0] D1 = 64'h0000_FFFF_0000_0000;
  localparam logic [63:0] D2 = 64'h8001_00FF_0001_0000;

  logic [2:0] n3_ready [5];
  int         n3_id    [4];
  int         n3_cnt   [4];

`ifdef HAMMING16_ARBITER_ACCUM_EN
  int exp_tot [4];
`endif

  logic [3:0]  rv, rclr;
  logic [63:0] rd;
  logic        ro;

  initial begin
    // Output fields: registered state seen during each row (previous grant).
    tbl[0]  = '{4'b0100, D1, 1'b1, 4'b0100, 1'b0, 2'd0, 5'd0,  16'h0000};
    tbl[1]  = '{4'b1000, D2, 1'b1, 4'b1000, 1'b1, 2'd2, 5'd16, 16'hFFFF};
    tbl[2]  = '{4'b1111, D2, 1'b1, 4'b0001, 1'b1, 2'd3, 5'd2,  16'h8001};
    tbl[3]  = '{4'b1111, D2, 1'b1, 4'b0010, 1'b1, 2'd0, 5'd0,  16'h0000};
    tbl[4]  = '{4'b1111, D2, 1'b1, 4'b0100, 1'b1, 2'd1, 5'd1,  16'h0001};
    tbl[5]  = '{4'b1111, D2, 1'b1, 4'b1000, 1'b1, 2'd2, 5'd8,  16'h00FF};
    tbl[6]  = '{4'b1111, D2, 1'b0, 4'b0000, 1'b1, 2'd3, 5'd2,  16'h8001};
    tbl[7]  = '{4'b1111, D2, 1'b0, 4'b0000, 1'b1, 2'd3, 5'd2,  16'h8001};
    tbl[8]  = '{4'b1111, D2, 1'b0, 4'b0000, 1'b1, 2'd3, 5'd2,  16'h8001};
    tbl[9]  = '{4'b1111, D2, 1'b1, 4'b0001, 1'b1, 2'd3, 5'd2,  16'h8001};
    tbl[10] = '{4'b0010, D2, 1'b1, 4'b0010, 1'b1, 2'd0, 5'd0,  16'h0000};
    tbl[11] = '{4'b0000, D2, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd1,  16'h0001};
    tbl[12] = '{4'b0000, D2, 1'b0, 4'b0000, 1'b0, 2'd1, 5'd1,  16'h0001};
    tbl[13] = '{4'b0001, D2, 1'b0, 4'b0001, 1'b0, 2'd1, 5'd1,  16'h0001};

    n3_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    n3_id    = '{0, 1, 2, 0};
    n3_cnt   = '{1, 2, 3, 1};

    rst_n = 1'b0;
    valid4 = 4'b1111; data4 = D2; ordy4 = 1'b1;
    valid3 = 3'b000;  data3 = 48'h0007_0003_0001; ordy3 = 1'b1;
`ifdef HAMMING16_ARBITER_ACCUM_EN
    clr4 = '0; clr3 = '0;
    exp_tot = '{4, 8, 12, 4};
`endif
    model_reset();

    // Reset state, with requesters asserting valid.
    @(negedge clk);
    check("rst_ready", 32'(ready4), 32'd0);
    check("rst_valid", 32'(ov4), 32'd0);
    check("rst_count", 32'(cnt4), 32'd0);
    check("rst_id", 32'(id4), 32'd0);
    check("rst_data", 32'(dat4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid4 = 4'b0000;

    // N_REQ=3 wrap: grants 0,1,2,0,1.
    valid3 = 3'b111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("n3_ready%0d", c), 32'(ready3), 32'(n3_ready[c]));
      if (c > 0) begin
        check($sformatf("n3_valid%0d", c), 32'(ov3), 32'd1);
        check($sformatf("n3_id%0d", c), 32'(id3), n3_id[c-1]);
        check($sformatf("n3_count%0d", c), 32'(cnt3), n3_cnt[c-1]);
      end
      @(posedge clk); #1;
    end
    valid3 = 3'b000;

    // Directed table.
    for (int r = 0; r < 14; r++) begin
      valid4 = tbl[r].valid; data4 = tbl[r].data; ordy4 = tbl[r].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", r), 32'(ready4), 32'(tbl[r].exp_ready));
      check($sformatf("tbl%0d_valid", r), 32'(ov4), 32'(tbl[r].exp_ov));
      check($sformatf("tbl%0d_id", r), 32'(id4), 32'(tbl[r].exp_id));
      check($sformatf("tbl%0d_count", r), 32'(cnt4), 32'(tbl[r].exp_cnt));
      check($sformatf("tbl%0d_data", r), 32'(dat4), 32'(tbl[r].exp_data));
      @(posedge clk); #1;
    end

    // Async reset while FULL, then requester 0 wins although pointer was at 1.
    valid4 = 4'b1111; ordy4 = 1'b0;
    #2;
    check("pre_rst_full", 32'(ov4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ov4), 32'd0);
    check("async_rst_ready", 32'(ready4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ordy4 = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(ready4), 32'b0001);
    @(posedge clk); #1;
    check("post_rst_id", 32'(id4), 32'd0);
    valid4 = 4'b0000;

`ifdef HAMMING16_ARBITER_ACCUM_EN
    rst_n = 1'b0; #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid4 = 4'b0010; data4 = 64'h0000_0000_000F_0000; ordy4 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      clr4 = (n == 3) ? 4'b0010 : 4'b0000;
      @(posedge clk); #1;
      check($sformatf("acc_total%0d", n), 32'(tot4), exp_tot[n]);
    end
    valid4 = 4'b0000; clr4 = '0;
`endif

    // Randomized traffic against the model.
    rst_n = 1'b0; #2;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 400; t++) begin
      rv   = 4'($urandom_range(0, 15));
      rd   = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rd[16*$urandom_range(0, 3) +: 16] = 16'hFFFF;
      ro   = ($urandom_range(0, 3) != 0);
      rclr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      valid4 = rv; data4 = rd; ordy4 = ro;
`ifdef HAMMING16_ARBITER_ACCUM_EN
      clr4 = rclr;
`endif
      @(negedge clk);
      check($sformatf("rnd%0d_ready", t), 32'(ready4), 32'(exp_grant(rv, ro)));
      check($sformatf("rnd%0d_valid", t), 32'(ov4), 32'(m_full));
      check($sformatf("rnd%0d_id", t), 32'(id4), m_id);
      check($sformatf("rnd%0d_count", t), 32'(cnt4), m_count);
      check($sformatf("rnd%0d_data", t), 32'(dat4), 32'(m_data));
`ifdef HAMMING16_ARBITER_ACCUM_EN
      check($sformatf("rnd%0d_total", t), 32'(tot4), 32'(m_out_total));
`endif
      @(posedge clk);
      model_step(rv, rd, ro, rclr);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming16_arbiter.md
# hamming16_arbiter

Round-robin arbiter that shares one 16-bit population-count datapath (`hamming16`, combinational, 5-bit count) between `N_REQ` requesters. Each requester offers 16-bit words over a valid/ready handshake. The block grants one word per cycle, counts its set bits, and holds the result in a single output register tagged with the requester index. It sits between the requester ports and any downstream consumer of bit-count results, and gives the shared counter one controlled point of access.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester-index width; derived, do not override.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `req_valid` input, `N_REQ` bits: bit i high means requester i offers `req_data[16*i +: 16]`.
- `req_data` input, `16*N_REQ` bits: packed request words.
- `req_ready` output, `N_REQ` bits: one-hot or zero. Bit i high means the word from requester i is taken this cycle.
- `out_valid` output, 1 bit: the output register holds a result.
- `out_ready` input, 1 bit: the consumer accepts the result this cycle.
- `out_count` output, 5 bits: set-bit count of the granted word, range 0..16.
- `out_id` output, `ID_W` bits: index of the requester that produced the result.
- `out_data` output, 16 bits: copy of the granted word.
- `acc_clr` input, `N_REQ` bits: per-requester total clear. Only present with `HAMMING16_ARBITER_ACCUM_EN`.
- `out_total` output, 21 bits: running total for `out_id`, including this result. Only present with `HAMMING16_ARBITER_ACCUM_EN`.

## Operation
- Output register has two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_accept` = EMPTY, or FULL with `out_ready`=1 (drain and refill in the same cycle).
- Arbitration:
  - `rr_ptr` (`ID_W` bits) holds the highest-priority index.
  - Among the asserted `req_valid` bits, the winner is the first index found scanning `rr_ptr`, `rr_ptr`+1, … modulo `N_REQ`.
  - `req_ready[winner]`=1 only when `can_accept`=1. All other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid` and `out_ready`. There is no combinational path from `req_data` to `req_ready`.
- Transfer: on a cycle with `req_valid[i]` && `req_ready[i]`:
  - the output register loads `out_count`=popcount(word), `out_id`=i and `out_data`=word;
  - the state becomes FULL;
  - `rr_ptr` becomes (i+1) mod `N_REQ`.
- No transfer with `out_ready`=1 while FULL: the state becomes EMPTY. `out_count`, `out_id` and `out_data` hold their last values.
- No transfer and no drain: all state holds, and `rr_ptr` does not move.
- The winner index is never an unused value (≥`N_REQ`). The modulo wrap applies for non-power-of-2 `N_REQ`.
- A requester may drop `req_valid` without a handshake. No word is lost or duplicated, because acceptance happens only on valid && ready.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `out_valid`=0, `out_count`=0, `out_id`=0, `out_data`=0;
  - `rr_ptr`=0, so requester 0 has highest priority;
  - all `req_ready`=0 while `rst_n` is low;
  - totals = 0 when accumulation is compiled in.
- Reset mid-transfer discards the pending result. The first post-reset grant goes to the lowest-indexed valid requester.
- Latency: `out_valid` rises on the edge that completes the request handshake, so the result is visible the cycle after the handshake.
- Throughput: 1 word per cycle while `out_ready` is held at 1.
- Backpressure: while FULL with `out_ready`=0, `req_ready` is all zero and the output fields are stable.
- Fairness: with all requesters continuously valid and `out_ready`=1, grants cycle 0,1,…,`N_REQ`-1,0,…. Each requester waits at most `N_REQ`-1 grants.

## Configuration
- Macro `HAMMING16_ARBITER_ACCUM_EN`.
- Defined:
  - one 21-bit running total per requester, which wraps modulo 2^21;
  - on a transfer from requester i, total[i] += popcount;
  - `out_total` is registered with the result and shows the updated total[i];
  - `acc_clr[i]` sets total[i] to 0 next cycle;
  - if `acc_clr[i]` and a transfer from i occur in the same cycle, total[i] = popcount of that word, and `out_total` shows it.
- Undefined: no totals; `acc_clr` and `out_total` ports are absent; all other behaviour is identical.

## Test plan
- Reset, then requester 2 alone sends 16'hFFFF with `out_ready`=1 → `req_ready`=4'b0100. Next cycle `out_valid`=1, `out_count`=16, `out_id`=2.
- All four valid (words 16'h0000, 16'h0001, 16'h00FF, 16'h8001), `out_ready`=1 for 4 cycles → `out_id` sequence 0,1,2,3; `out_count` sequence 0,1,8,2; one result per cycle.
- FULL with `out_ready`=0 for 3 cycles while requesters are valid → `req_ready`=0 and outputs stable. The cycle `out_ready`=1, the next-in-order requester is granted, with no bubble.
- `N_REQ`=3, all valid → grants 0,1,2,0; `out_id` never reaches 3.
- `rst_n` pulled low while FULL → `out_valid`=0 immediately, without waiting for a clock. After release, requester 0 wins even if it was just served.
- With the macro: requester 1 sends 16'h000F three times → `out_total` 4,8,12. Asserting `acc_clr[1]` together with a fourth send → `out_total`=4.
